// File: rtl/util_sync_filter_if.sv
// Handshake-free signal bundle for util_sync_filter.
// master drives the raw bits and controls, slave returns filtered state.
interface util_sync_filter_if #(
  parameter int WIDTH = 1
);
  logic             enable_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] event_clr_i;
  logic [WIDTH-1:0] level_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] event_o;

  modport master (
    output enable_i, data_i, event_clr_i,
    input  level_o, rise_o, fall_o, event_o
  );

  modport slave (
    input  enable_i, data_i, event_clr_i,
    output level_o, rise_o, fall_o, event_o
  );
endinterface

// File: rtl/util_sync_filter.sv
// Per-bit glitch filter with edge pulses and sticky W1C events.
// Level flips after FILTER_CYCLES consecutive differing samples.
module util_sync_filter #(
  parameter int WIDTH         = 1,
  parameter int FILTER_CYCLES = 4,
  parameter bit EVENT_RISE    = 1'b1,
  parameter bit EVENT_FALL    = 1'b0
) (
  input logic             clk_i,
  input logic             reset_n_i,
  util_sync_filter_if.slave bus
);
  localparam int CW = (FILTER_CYCLES < 2) ? 1
                    : $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] event_q;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] set;

  always_comb begin
    diff = '0;
    flip = '0;
    set  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      diff[b] = bus.enable_i && (bus.data_i[b] != level_q[b]);
      flip[b] = diff[b] && (cnt[b] == LAST);
      set[b]  = flip[b] &&
                ((EVENT_RISE && bus.data_i[b]) ||
                 (EVENT_FALL && !bus.data_i[b]));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        rise_q[b] <= flip[b] && bus.data_i[b];
        fall_q[b] <= flip[b] && !bus.data_i[b];
        if (flip[b]) begin
          level_q[b] <= bus.data_i[b];
          cnt[b]     <= '0;
        end else if (diff[b]) begin
          cnt[b] <= cnt[b] + 1'b1;
        end else begin
          cnt[b] <= '0;
        end
        // a new event beats a simultaneous clear
        if (set[b]) event_q[b] <= 1'b1;
        else if (bus.event_clr_i[b]) event_q[b] <= 1'b0;
      end
    end
  end

  assign bus.level_o = level_q;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;
  assign bus.event_o = event_q;
endmodule

// File: tb/tb_util_sync_filter.sv
// Directed bench for util_sync_filter across three configurations.
// Expected values are hand-computed per step.
module tb_util_sync_filter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  util_sync_filter_if #(.WIDTH(1)) if0 ();
  util_sync_filter_if #(.WIDTH(1)) if1 ();
  util_sync_filter_if #(.WIDTH(4)) if2 ();

  util_sync_filter #(
    .WIDTH(1), .FILTER_CYCLES(4),
    .EVENT_RISE(1'b1), .EVENT_FALL(1'b0)
  ) u0 (.clk_i(clk), .reset_n_i(reset_n), .bus(if0.slave));

  util_sync_filter #(
    .WIDTH(1), .FILTER_CYCLES(4),
    .EVENT_RISE(1'b0), .EVENT_FALL(1'b1)
  ) u1 (.clk_i(clk), .reset_n_i(reset_n), .bus(if1.slave));

  util_sync_filter #(
    .WIDTH(4), .FILTER_CYCLES(1),
    .EVENT_RISE(1'b1), .EVENT_FALL(1'b0)
  ) u2 (.clk_i(clk), .reset_n_i(reset_n), .bus(if2.slave));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic chk0(input string tag, input logic l,
                      input logic r, input logic e);
    check({tag, ".lvl"}, 32'(if0.level_o), 32'(l));
    check({tag, ".rise"}, 32'(if0.rise_o), 32'(r));
    check({tag, ".evt"}, 32'(if0.event_o), 32'(e));
  endtask

  initial begin
    if0.enable_i = 1'b1; if0.data_i = '0; if0.event_clr_i = '0;
    if1.enable_i = 1'b1; if1.data_i = '0; if1.event_clr_i = '0;
    if2.enable_i = 1'b1; if2.data_i = '0; if2.event_clr_i = '0;
    #2;
    check("rst.lvl0", 32'(if0.level_o), 0);
    check("rst.rise0", 32'(if0.rise_o), 0);
    check("rst.fall0", 32'(if0.fall_o), 0);
    check("rst.evt0", 32'(if0.event_o), 0);
    check("rst.lvl2", 32'(if2.level_o), 0);
    do_reset();

    // basic flip
    if0.data_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk0($sformatf("basic%0d", i), 0, 0, 0);
    end
    tick();
    chk0("basic4", 1, 1, 1);
    check("basic4.fall", 32'(if0.fall_o), 0);
    tick();
    chk0("basic5", 1, 0, 1);

    // glitch rejection
    do_reset();
    if0.data_i = 1'b1;
    tick(3);
    chk0("gl.h3", 0, 0, 0);
    if0.data_i = 1'b0;
    tick();
    chk0("gl.l1", 0, 0, 0);
    if0.data_i = 1'b1;
    tick(3);
    chk0("gl.h3b", 0, 0, 0);
    tick();
    chk0("gl.h4b", 1, 1, 1);
    tick();
    chk0("gl.after", 1, 0, 1);

    // set/clear collision
    do_reset();
    if0.data_i = 1'b1;
    tick(3);
    if0.event_clr_i = 1'b1;
    tick();
    chk0("col.set", 1, 1, 1);
    tick();
    if0.event_clr_i = 1'b0;
    chk0("col.clr", 1, 0, 0);

    // enable drop mid-count
    do_reset();
    if0.data_i = 1'b1;
    tick(2);
    if0.enable_i = 1'b0;
    tick();
    chk0("en.off", 0, 0, 0);
    if0.enable_i = 1'b1;
    tick(3);
    chk0("en.re3", 0, 0, 0);
    tick();
    chk0("en.re4", 1, 1, 1);

    // async reset mid-count while level is 1
    if0.data_i = 1'b0;
    tick(2);
    chk0("ar.pre", 1, 0, 1);
    reset_n = 1'b0;
    #1;
    chk0("ar.async", 0, 0, 0);
    #2;
    reset_n = 1'b1;
    if0.data_i = 1'b1;
    tick(3);
    chk0("ar.post3", 0, 0, 0);
    tick();
    chk0("ar.post4", 1, 1, 1);

    // falling-edge events
    do_reset();
    if1.data_i = 1'b1;
    tick(4);
    check("fe.lvl1", 32'(if1.level_o), 1);
    check("fe.noevt", 32'(if1.event_o), 0);
    if1.data_i = 1'b0;
    tick(3);
    check("fe.hold", 32'(if1.level_o), 1);
    tick();
    check("fe.lvl0", 32'(if1.level_o), 0);
    check("fe.fall", 32'(if1.fall_o), 1);
    check("fe.rise", 32'(if1.rise_o), 0);
    check("fe.evt", 32'(if1.event_o), 1);
    if1.event_clr_i = 1'b1;
    tick();
    if1.event_clr_i = 1'b0;
    check("fe.clr", 32'(if1.event_o), 0);
    check("fe.fall0", 32'(if1.fall_o), 0);

    // multi-bit, no filtering
    do_reset();
    if2.data_i = 4'b1010;
    tick();
    check("mb.lvl1", 32'(if2.level_o), 32'b1010);
    check("mb.rise1", 32'(if2.rise_o), 32'b1010);
    check("mb.fall1", 32'(if2.fall_o), 32'b0000);
    if2.data_i = 4'b0110;
    tick();
    check("mb.lvl2", 32'(if2.level_o), 32'b0110);
    check("mb.rise2", 32'(if2.rise_o), 32'b0100);
    check("mb.fall2", 32'(if2.fall_o), 32'b1000);
    check("mb.evt2", 32'(if2.event_o), 32'b1110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
